// File: rtl/event_encoder_3_pkg.sv
// -----------------------------------------------------------------------------
// event_encoder_3_pkg
//   Shared definitions for the event encoder block.
//   - NUM_LINES / CODE_W : number of event lines and the width of their index
//   - state_e            : two-state handshake FSM encoding
//   - onehot()           : index -> one-hot line mask, used to clear the
//                          pending bit that was just accepted
// -----------------------------------------------------------------------------
package event_encoder_3_pkg;

  localparam int NUM_LINES = 8;
  localparam int CODE_W    = $clog2(NUM_LINES);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  function automatic logic [NUM_LINES-1:0] onehot(input logic [CODE_W-1:0] idx);
    logic [NUM_LINES-1:0] one;
    one = {{(NUM_LINES-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/event_encoder_3_prio_enc_8.sv
// -----------------------------------------------------------------------------
// prio_enc_8
//   Combinational 8-to-3 fixed-priority encoder.
//   Parameter LOW_FIRST : 1 = lowest set index wins, 0 = highest set index wins
//   Ports:
//     vec  in  [7:0] request vector
//     idx  out [2:0] index of the winning request (0 when vec == 0)
//     any  out       at least one request is set
// -----------------------------------------------------------------------------
module prio_enc_8
  import event_encoder_3_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic [NUM_LINES-1:0] vec,
  output logic [CODE_W-1:0]    idx,
  output logic                 any
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    idx = '0;
    any = |vec;
    if (LOW_FIRST) begin
      // Scan downwards: the last hit, i.e. the lowest index, sticks.
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end else begin
      // Scan upwards: the last hit, i.e. the highest index, sticks.
      for (int i = 0; i < NUM_LINES; i++) begin
        if (vec[i]) idx = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/event_encoder_3.sv
// -----------------------------------------------------------------------------
// event_encoder_3
//   Interrupt / exception cause encoder. Eight event lines each own a sticky
//   pending bit; a fixed-priority encoder selects one pending line and offers
//   its index over a valid/ready handshake, holding it stable until accepted.
//
//   Parameters:
//     EDGE_MODE : 1 = pending set on rising edge of dN, 0 = set while dN high
//     LOW_FIRST : 1 = d0 highest priority, 0 = d7 highest priority
//   Ports:
//     clk          in       rising-edge clock
//     rst_n        in       asynchronous active-low reset
//     d0..d7       in       event lines, synchronous to clk
//     ready        in       consumer accepts code this cycle
//     clr_overrun  in       synchronous clear of overrun
//     code         out [2:0] index of the offered event
//     valid        out      code is meaningful
//     pending      out [7:0] current pending bits, bit N = dN
//     overrun      out      sticky: an event hit an already-pending line
// -----------------------------------------------------------------------------
module event_encoder_3
  import event_encoder_3_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 d0,
  input  logic                 d1,
  input  logic                 d2,
  input  logic                 d3,
  input  logic                 d4,
  input  logic                 d5,
  input  logic                 d6,
  input  logic                 d7,
  input  logic                 ready,
  input  logic                 clr_overrun,
  output logic [CODE_W-1:0]    code,
  output logic                 valid,
  output logic [NUM_LINES-1:0] pending,
  output logic                 overrun
);

  logic [NUM_LINES-1:0] d_vec;
  logic [NUM_LINES-1:0] prev_q,    prev_d;
  logic [NUM_LINES-1:0] pending_q, pending_d;
  logic [NUM_LINES-1:0] rise_vec;
  logic [NUM_LINES-1:0] set_vec;
  logic [NUM_LINES-1:0] clr_vec;
  logic                 overrun_q, overrun_d;
  logic                 ovr_hit;
  logic                 accept;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [CODE_W-1:0]    enc_idx;
  logic                 enc_any;
  state_e               state_q, state_d;

  // ---------------------------------------------------------------------------
  // Pending / overrun datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    d_vec    = {d7, d6, d5, d4, d3, d2, d1, d0};
    prev_d   = d_vec;
    rise_vec = d_vec & ~prev_q;
    set_vec  = EDGE_MODE ? rise_vec : d_vec;

    // A handshake completes only while an index is actually being offered;
    // ready in IDLE has no effect.
    accept   = (state_q == ST_PRESENT) && ready;
    clr_vec  = accept ? onehot(code_q) : '0;

    // Set is ORed in after the clear so a new event on the line being
    // accepted this edge is kept rather than lost.
    pending_d = (pending_q & ~clr_vec) | set_vec;

    // Only a fresh rising edge can be a lost event: in level mode a line held
    // high keeps re-setting its own pending bit, which is not an overrun.
    ovr_hit   = |(rise_vec & pending_q & ~clr_vec);
    overrun_d = ovr_hit | (overrun_q & ~clr_overrun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      prev_q    <= prev_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Priority selection over the registered pending bits
  // ---------------------------------------------------------------------------
  prio_enc_8 #(
    .LOW_FIRST (LOW_FIRST)
  ) u_prio_enc (
    .vec (pending_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // ---------------------------------------------------------------------------
  // Handshake FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM: next-state logic
  //   code is loaded only on the IDLE->PRESENT transition, which freezes it
  //   for the whole offer even if a higher-priority line becomes pending.
  //   Returning to IDLE after every accept gives one bubble cycle, so the
  //   encoder always re-evaluates priority on the updated pending bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_any) begin
          code_d  = enc_idx;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    valid   = (state_q == ST_PRESENT);
    code    = code_q;
    pending = pending_q;
    overrun = overrun_q;
  end

endmodule

// File: tb/tb_event_encoder_3.sv
// -----------------------------------------------------------------------------
// tb_event_encoder_3
//   Two instances: dut (EDGE_MODE=1, LOW_FIRST=1) and dut2 (EDGE_MODE=0,
//   LOW_FIRST=0). Stimulus pushes the codes it expects to be accepted into a
//   per-instance queue; a monitor pops and compares on every handshake.
//   Register-level expectations (pending, valid, code, overrun) are checked
//   directly by the stimulus process one time unit after the clock edge.
// -----------------------------------------------------------------------------
module tb_event_encoder_3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d, d2v;
  logic       ready, ready2;
  logic       clr, clr2;

  logic [2:0] code, code2;
  logic       valid, valid2;
  logic [7:0] pending, pending2;
  logic       overrun, overrun2;

  logic [2:0] exp_q[$];
  logic [2:0] exp_q2[$];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  event_encoder_3 #(.EDGE_MODE(1'b1), .LOW_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
    .ready(ready), .clr_overrun(clr),
    .code(code), .valid(valid), .pending(pending), .overrun(overrun)
  );

  event_encoder_3 #(.EDGE_MODE(1'b0), .LOW_FIRST(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .d0(d2v[0]), .d1(d2v[1]), .d2(d2v[2]), .d3(d2v[3]),
    .d4(d2v[4]), .d5(d2v[5]), .d6(d2v[6]), .d7(d2v[7]),
    .ready(ready2), .clr_overrun(clr2),
    .code(code2), .valid(valid2), .pending(pending2), .overrun(overrun2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [7:0] p, input logic v,
                      input logic [2:0] c, input logic o);
    check({tag, "_pending"}, pending, p);
    check({tag, "_valid"},   valid,   v);
    if (v) check({tag, "_code"}, code, c);
    check({tag, "_overrun"}, overrun, o);
  endtask

  task automatic chk2(input string tag, input logic [7:0] p, input logic v,
                      input logic [2:0] c, input logic o);
    check({tag, "_pending2"}, pending2, p);
    check({tag, "_valid2"},   valid2,   v);
    if (v) check({tag, "_code2"}, code2, c);
    check({tag, "_overrun2"}, overrun2, o);
  endtask

  // Scoreboard monitor: a handshake is seen at the falling edge before the
  // rising edge that completes it.
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sb_dut_unexpected: got code %0d, expected none", code);
          end else begin
            e = exp_q.pop_front();
            check("sb_dut_code", code, e);
          end
        end
        if (valid2 && ready2) begin
          if (exp_q2.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sb_dut2_unexpected: got code %0d, expected none", code2);
          end else begin
            e = exp_q2.pop_front();
            check("sb_dut2_code", code2, e);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; d = '0; d2v = '0; ready = 1'b0; ready2 = 1'b0; clr = 1'b0; clr2 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    check("reset_code", code, 3'd0);
    chk2("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step();

    // --- d5 pulse, ready held high ---
    ready = 1'b1;
    d = 8'h20; exp_q.push_back(3'd5);
    step(); chk1("d5_pend", 8'h20, 1'b0, 3'd0, 1'b0);
    d = 8'h00;
    step(); chk1("d5_offer", 8'h20, 1'b1, 3'd5, 1'b0);
    step(); chk1("d5_acc", 8'h00, 1'b0, 3'd0, 1'b0);

    // --- d5 held high: exactly one event ---
    d = 8'h20; exp_q.push_back(3'd5);
    step(); chk1("hold_pend", 8'h20, 1'b0, 3'd0, 1'b0);
    step(); chk1("hold_offer", 8'h20, 1'b1, 3'd5, 1'b0);
    step(); chk1("hold_acc", 8'h00, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); chk1("hold_quiet", 8'h00, 1'b0, 3'd0, 1'b0);
    end
    d = 8'h00;
    step();

    // --- d2 + d6 together, ready low: code 2 held, then 6 ---
    ready = 1'b0;
    d = 8'h44; exp_q.push_back(3'd2); exp_q.push_back(3'd6);
    step(); chk1("d26_pend", 8'h44, 1'b0, 3'd0, 1'b0);
    d = 8'h00;
    step(); chk1("d26_offer", 8'h44, 1'b1, 3'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(); chk1("d26_hold", 8'h44, 1'b1, 3'd2, 1'b0);
    end
    ready = 1'b1;
    step(); chk1("d26_acc2", 8'h40, 1'b0, 3'd0, 1'b0);
    step(); chk1("d26_offer6", 8'h40, 1'b1, 3'd6, 1'b0);
    step(); chk1("d26_acc6", 8'h00, 1'b0, 3'd0, 1'b0);

    // --- code 6 frozen while higher-priority d2, d1 arrive ---
    ready = 1'b0;
    d = 8'h40; exp_q.push_back(3'd6); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    step(); chk1("frz_pend", 8'h40, 1'b0, 3'd0, 1'b0);
    d = 8'h00;
    step(); chk1("frz_offer6", 8'h40, 1'b1, 3'd6, 1'b0);
    d = 8'h04;
    step(); chk1("frz_d2", 8'h44, 1'b1, 3'd6, 1'b0);
    d = 8'h02;
    step(); chk1("frz_d1", 8'h46, 1'b1, 3'd6, 1'b0);
    d = 8'h00;
    step(); chk1("frz_hold", 8'h46, 1'b1, 3'd6, 1'b0);
    ready = 1'b1;
    step(); chk1("frz_acc6", 8'h06, 1'b0, 3'd0, 1'b0);
    step(); chk1("frz_offer1", 8'h06, 1'b1, 3'd1, 1'b0);
    step(); chk1("frz_acc1", 8'h04, 1'b0, 3'd0, 1'b0);
    step(); chk1("frz_offer2", 8'h04, 1'b1, 3'd2, 1'b0);
    step(); chk1("frz_acc2", 8'h00, 1'b0, 3'd0, 1'b0);

    // --- overrun on d3, clear, and clear/set collision ---
    ready = 1'b0;
    d = 8'h08; exp_q.push_back(3'd3);
    step(); chk1("ovr_pend", 8'h08, 1'b0, 3'd0, 1'b0);
    d = 8'h00;
    step(); chk1("ovr_offer", 8'h08, 1'b1, 3'd3, 1'b0);
    d = 8'h08;
    step(); chk1("ovr_hit", 8'h08, 1'b1, 3'd3, 1'b1);
    d = 8'h00;
    step(); chk1("ovr_sticky", 8'h08, 1'b1, 3'd3, 1'b1);
    clr = 1'b1;
    step(); chk1("ovr_clr", 8'h08, 1'b1, 3'd3, 1'b0);
    d = 8'h08;
    step(); chk1("ovr_setwins", 8'h08, 1'b1, 3'd3, 1'b1);
    d = 8'h00; clr = 1'b0;
    step(); chk1("ovr_sticky2", 8'h08, 1'b1, 3'd3, 1'b1);
    clr = 1'b1;
    step(); chk1("ovr_clr2", 8'h08, 1'b1, 3'd3, 1'b0);
    clr = 1'b0; ready = 1'b1;
    step(); chk1("ovr_acc", 8'h00, 1'b0, 3'd0, 1'b0);

    // --- new d4 edge on the accepting edge of code 4 ---
    ready = 1'b0;
    d = 8'h10; exp_q.push_back(3'd4); exp_q.push_back(3'd4);
    step(); chk1("cs_pend", 8'h10, 1'b0, 3'd0, 1'b0);
    d = 8'h00;
    step(); chk1("cs_offer", 8'h10, 1'b1, 3'd4, 1'b0);
    d = 8'h10; ready = 1'b1;
    step(); chk1("cs_acc_set", 8'h10, 1'b0, 3'd0, 1'b0);
    d = 8'h00;
    step(); chk1("cs_reoffer", 8'h10, 1'b1, 3'd4, 1'b0);
    step(); chk1("cs_acc", 8'h00, 1'b0, 3'd0, 1'b0);

    // --- async reset mid-handshake with overrun set ---
    ready = 1'b0;
    d = 8'h01;
    step();
    d = 8'h00;
    step(); chk1("mr_offer", 8'h01, 1'b1, 3'd0, 1'b0);
    d = 8'h01;
    step(); chk1("mr_ovr", 8'h01, 1'b1, 3'd0, 1'b1);
    d = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk1("mr_reset", 8'h00, 1'b0, 3'd0, 1'b0);
    check("mr_reset_code", code, 3'd0);
    step();
    rst_n = 1'b1;
    step(); chk1("mr_after", 8'h00, 1'b0, 3'd0, 1'b0);

    // --- dut2: level mode, d7 highest priority ---
    d2v = 8'h81; exp_q2.push_back(3'd7); exp_q2.push_back(3'd0);
    step(); chk2("hf_pend", 8'h81, 1'b0, 3'd0, 1'b0);
    d2v = 8'h00;
    step(); chk2("hf_offer7", 8'h81, 1'b1, 3'd7, 1'b0);
    ready2 = 1'b1;
    step(); chk2("hf_acc7", 8'h01, 1'b0, 3'd0, 1'b0);
    step(); chk2("hf_offer0", 8'h01, 1'b1, 3'd0, 1'b0);
    step(); chk2("hf_acc0", 8'h00, 1'b0, 3'd0, 1'b0);

    // --- dut2: held-high line re-sets itself, never an overrun ---
    ready2 = 1'b0;
    d2v = 8'h04; exp_q2.push_back(3'd2); exp_q2.push_back(3'd2);
    step(); chk2("lv_pend", 8'h04, 1'b0, 3'd0, 1'b0);
    step(); chk2("lv_offer", 8'h04, 1'b1, 3'd2, 1'b0);
    step(); chk2("lv_hold", 8'h04, 1'b1, 3'd2, 1'b0);
    ready2 = 1'b1;
    step(); chk2("lv_acc_set", 8'h04, 1'b0, 3'd0, 1'b0);
    d2v = 8'h00;
    step(); chk2("lv_reoffer", 8'h04, 1'b1, 3'd2, 1'b0);
    step(); chk2("lv_acc", 8'h00, 1'b0, 3'd0, 1'b0);
    ready2 = 1'b0;
    step();

    check("sb_dut_drained", exp_q.size(), 0);
    check("sb_dut2_drained", exp_q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/event_encoder_3.md
Name: event_encoder_3

Overview:
- Inverse of decoder_3: takes eight event lines d0..d7 and returns a 3-bit index over a valid/ready handshake.
- Each line has a sticky pending bit, set by a rising edge or by level, selected by parameter.
- A fixed-priority encoder picks one pending line, and the block holds that index stable until the consumer accepts it.
- Sits between peripheral/ALU status lines and the control unit, acting as the interrupt/exception cause encoder.

Parameters:
EDGE_MODE, 1, 1 = set pending on rising edge of dN; 0 = set pending whenever dN is high
LOW_FIRST, 1, 1 = d0 is highest priority; 0 = d7 is highest priority

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
d0..d7  input  1 each  event lines, synchronous to clk
ready  input  1  consumer accepts code this cycle
clr_overrun  input  1  synchronous clear of overrun
code  output  3  index of the offered event
valid  output  1  code is meaningful
pending  output  8  current pending bits, bit N = dN
overrun  output  1  sticky flag: an event was lost

Behaviour:
- Reset (async assert, sync release) clears: code=3'b000, valid=0, pending=8'h00, overrun=0, previous-input register=8'h00, state=IDLE.
- Set condition for bit N:
  - EDGE_MODE=1: dN=1 and prevN=0 at the clock edge. prev is the registered copy of d0..d7.
  - EDGE_MODE=0: dN=1.
  - A set condition updates pendingN at that edge, so it is visible the next cycle.
- Clear: pendingN clears on the edge where valid && ready && code==N.
- Clear and set on the same bit at the same edge: set wins, and the bit stays pending.
- Overrun: goes to 1 when a set condition hits a bit that is already pending and is not being cleared that edge.
  - EDGE_MODE=0 only: a held-high line does not count as overrun.
  - clr_overrun=1 clears overrun. If clr_overrun and a new overrun coincide, set wins.
- State machine, two states:
  - IDLE: valid=0. When pending!=0, at the next edge load code = priority-encoded pending, set valid=1, go to PRESENT.
  - PRESENT: valid=1, and code is frozen while ready=0, even if a higher-priority bit becomes pending.
  - PRESENT with ready=1: handshake completes at that edge; the matching pending bit clears; go to IDLE with valid=0.
  - Result: one bubble cycle between consecutive accepts. Sustained throughput is one code every 2 cycles.
- Latency (EDGE_MODE=1, IDLE): dN rises before edge k → pending at k → valid=1, code=N after edge k+1.
- ready while valid=0 is ignored.
- Priority: LOW_FIRST=1 picks the lowest set index; LOW_FIRST=0 picks the highest set index.
- pending=8'h00 in IDLE: valid stays 0 and code holds its last value. The consumer must not interpret code while valid=0.
- Reset mid-handshake: everything returns immediately to reset values; no partial state is kept.
- prev register updates every cycle regardless of state.

Decomposition:
- Shared package/header: state encodings ST_IDLE=1'b0 and ST_PRESENT=1'b1, and constant NUM_LINES=8.
- One sub-module: prio_enc_8 (combinational). Inputs: 8-bit vector and LOW_FIRST. Outputs: 3-bit index and any flag.
- The top level holds the pending/prev/overrun registers and the FSM.

Test Plan:
- Reset → code=000, valid=0, pending=00, overrun=0. Also assert rst_n=0 while valid=1: all outputs clear asynchronously, before the next clk.
- EDGE_MODE=1, LOW_FIRST=1, ready=1:
  - pulse d5 for 1 cycle → pending=20h after edge k, then valid=1, code=101 after k+1.
  - accept → pending=00, valid=0.
  - holding d5 high afterwards produces no new event.
- Pulse d2 and d6 together, ready=0 → valid=1, code=010, held for 5 cycles. Then ready=1 → code=110 offered 2 cycles later; after the second accept pending=00.
- With code=110 offered and ready=0, raise d1 → code stays 110, pending=46h. After accept, the next code is 001.
- Second rising edge on d3 while pending[3]=1 → overrun=1, pending unchanged. clr_overrun=1 → overrun=0.
- Rising edge on d4 on the same edge that accepts code=100 → pending[4] remains 1 and code=100 is re-offered. Also with LOW_FIRST=0 and pending=81h → code=111 first.
